// File: rtl/riscv_pkg.sv
// Shared RV32I core constants: register width, register count and x0 index.
// Pure definitions; no latency or flow control.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage : riscv_pkg

// File: rtl/register_file.sv
// Integer register file: 2 combinational read ports with WB->ID write-through, 1 write port; x0 reads 0.
// Latency: reads zero-cycle, writes land on the clk edge; no backpressure (always accepts a write).
module register_file
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr1,
    input  logic [ADDR_WIDTH-1:0] read_addr2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] rd_addr [2];
    logic [DATA_WIDTH-1:0] rd_data [2];

    // Only a real destination with reset released may write or be forwarded.
    assign wr_en = reg_write && !rst && (write_addr != ZERO_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[write_addr] <= write_data;
        end
    end

    assign rd_addr[0] = read_addr1;
    assign rd_addr[1] = read_addr2;

    // Same read mux for both ports; forwarding lets WB and ID overlap in one cycle.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            if (rd_addr[p] == ZERO_ADDR) begin
                rd_data[p] = '0;
            end else if (wr_en && (rd_addr[p] == write_addr)) begin
                rd_data[p] = write_data;
            end else begin
                rd_data[p] = regs[rd_addr[p]];
            end
        end
    end

    assign read_data1 = rd_data[0];
    assign read_data2 = rd_data[1];

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: vector table, corner-case sequences, random traffic vs. array model.
// Latency: n/a; backpressure: n/a.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic        reg_write;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [4:0]  read_addr1;
    logic [4:0]  read_addr2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [32];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [11];

    register_file dut (
        .clk        (clk),
        .rst        (rst),
        .reg_write  (reg_write),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr1 (read_addr1),
        .read_addr2 (read_addr2),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected read value straight from the architectural rules.
    function automatic logic [31:0] model_read(input logic [4:0] ra, input logic r,
                                               input logic we, input logic [4:0] wa,
                                               input logic [31:0] wd);
        if (ra == 5'd0) return 32'h0;
        if (r) return 32'h0;
        if (we && wa == ra) return wd;
        return model[ra];
    endfunction

    task automatic model_commit();
        if (!rst && reg_write && write_addr != 5'd0) model[write_addr] = write_data;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'd1, 32'hDEADBEEF, 5'd1, 5'd0, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b1, 5'd2, 32'h12345678, 5'd1, 5'd2, 32'hDEADBEEF, 32'h12345678};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,        5'd2, 5'd1, 32'h12345678, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h0,        32'h0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd1, 32'h0,        32'hDEADBEEF};
        vecs[5]  = '{1'b1, 5'd3, 32'h00000011, 5'd3, 5'd4, 32'h00000011, 32'h0};
        vecs[6]  = '{1'b1, 5'd3, 32'hCAFEBABE, 5'd3, 5'd3, 32'hCAFEBABE, 32'hCAFEBABE};
        vecs[7]  = '{1'b0, 5'd3, 32'h55555555, 5'd3, 5'd3, 32'hCAFEBABE, 32'hCAFEBABE};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd2, 32'hCAFEBABE, 32'h12345678};
        vecs[9]  = '{1'b1, 5'd5, 32'hA5A5A5A5, 5'd5, 5'd1, 32'hA5A5A5A5, 32'hDEADBEEF};
        vecs[10] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 32'hA5A5A5A5, 32'h0};

        model_clear();
        rst        = 1'b1;
        reg_write  = 1'b0;
        write_addr = 5'd0;
        write_data = 32'h0;
        read_addr1 = 5'd0;
        read_addr2 = 5'd0;
        #10;
        rst = 1'b0;

        foreach (vecs[k]) ;
        begin
            logic [4:0] raddr [3];
            raddr[0] = 5'd1; raddr[1] = 5'd15; raddr[2] = 5'd31;
            for (int i = 0; i < 3; i++) begin
                read_addr1 = raddr[i];
                read_addr2 = raddr[i];
                #1;
                check("reset_rd1", read_data1, 32'h0);
                check("reset_rd2", read_data2, 32'h0);
            end
        end

        // Each vector: drive at negedge, check pre-edge (bypass visible), commit on posedge.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            reg_write  = vecs[i].we;
            write_addr = vecs[i].wa;
            write_data = vecs[i].wd;
            read_addr1 = vecs[i].ra1;
            read_addr2 = vecs[i].ra2;
            #1;
            check($sformatf("vec%0d_rd1", i), read_data1, vecs[i].exp1);
            check($sformatf("vec%0d_rd2", i), read_data2, vecs[i].exp2);
            @(posedge clk);
            model_commit();
        end

        // Reset mid-operation overrides a same-edge write and suppresses forwarding.
        @(negedge clk);
        reg_write  = 1'b1;
        write_addr = 5'd5;
        write_data = 32'h1;
        read_addr1 = 5'd5;
        read_addr2 = 5'd1;
        rst        = 1'b1;
        #1;
        check("rst_hold_rd1", read_data1, 32'h0);
        check("rst_hold_rd2", read_data2, 32'h0);
        model_clear();
        @(posedge clk);
        #1;
        check("rst_edge_x5", read_data1, 32'h0);
        @(negedge clk);
        reg_write = 1'b0;
        rst       = 1'b0;
        #1;
        check("rst_release_x5", read_data1, 32'h0);
        check("rst_release_x1", read_data2, 32'h0);

        // Asynchronous clear between edges.
        @(negedge clk);
        reg_write  = 1'b1;
        write_addr = 5'd7;
        write_data = 32'h00000077;
        @(posedge clk);
        model_commit();
        @(negedge clk);
        reg_write  = 1'b0;
        read_addr1 = 5'd7;
        read_addr2 = 5'd7;
        #1;
        check("async_pre_x7", read_data1, 32'h00000077);
        #1;
        rst = 1'b1;
        #1;
        check("async_clr_rd1", read_data1, 32'h0);
        check("async_clr_rd2", read_data2, 32'h0);
        model_clear();
        #1;
        rst = 1'b0;

        // Random traffic; read addresses often collide with the write address.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] e1;
            logic [31:0] e2;
            @(negedge clk);
            reg_write  = 1'($urandom_range(0, 1));
            write_addr = 5'($urandom_range(0, 31));
            write_data = $urandom;
            read_addr1 = ($urandom_range(0, 3) == 0) ? write_addr : 5'($urandom_range(0, 31));
            read_addr2 = ($urandom_range(0, 3) == 0) ? write_addr : 5'($urandom_range(0, 31));
            #1;
            e1 = model_read(read_addr1, rst, reg_write, write_addr, write_data);
            e2 = model_read(read_addr2, rst, reg_write, write_addr, write_data);
            check("rand_rd1", read_data1, e1);
            check("rand_rd2", read_data2, e2);
            @(posedge clk);
            model_commit();
        end

        // Final sweep of every register with writes idle.
        @(negedge clk);
        reg_write = 1'b0;
        for (int a = 0; a < 32; a++) begin
            read_addr1 = 5'(a);
            read_addr2 = 5'(31 - a);
            #1;
            check("sweep_rd1", read_data1, (a == 0) ? 32'h0 : model[a]);
            check("sweep_rd2", read_data2, (a == 31) ? 32'h0 : model[31 - a]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_register_file
